// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Couples a word-wide write-burst stream to the memory's word-write port and
// round-robin arbitrates two byte readers onto the memory's byte-read port.
//
// Write FSM states:
//   state | meaning
//   IDLE  | waiting for iWrStart; the only state that samples base/count
//   BURST | accepting stream words, one memory write per accepted word
//   DONE  | single cycle announcing burst completion on oWrDone
//
// Ports
//   iClk, iRst_n            clock, async active-low reset
//   iWrStart/ivWrBase/ivWrCount  burst start, base word address, word count
//   iWrValid/ivWrData/oWrReady   write stream handshake
//   iWrAbort                terminate the running burst
//   oWrDone/oWrAborted      one-cycle completion / abort pulses
//   iRdReq0/1, ivRdAddr0/1  byte read requests and addresses
//   oRdGnt0/1               one-cycle grant pulses
//   oRdValid0/1, ovRdData   read return strobes and shared byte data
//   oMemWE/ovMemAddrA/ovMemDataA  memory word-write port
//   ovMemAddrB/ivMemDataB   memory byte-read port
//   oBusy                   burst active or reads still in flight
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int RD_LAT    = 2,
    parameter int MAX_WORDS = 1024
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iWrStart,
    input  logic [9:0]  ivWrBase,
    input  logic [10:0] ivWrCount,
    input  logic        iWrValid,
    input  logic [31:0] ivWrData,
    output logic        oWrReady,
    input  logic        iWrAbort,
    output logic        oWrDone,
    output logic        oWrAborted,
    input  logic        iRdReq0,
    input  logic        iRdReq1,
    input  logic [11:0] ivRdAddr0,
    input  logic [11:0] ivRdAddr1,
    output logic        oRdGnt0,
    output logic        oRdGnt1,
    output logic        oRdValid0,
    output logic        oRdValid1,
    output logic [7:0]  ovRdData,
    output logic        oMemWE,
    output logic [9:0]  ovMemAddrA,
    output logic [31:0] ovMemDataA,
    output logic [11:0] ovMemAddrB,
    input  logic [7:0]  ivMemDataB,
    output logic        oBusy
);

    localparam logic [10:0] MAX_CNT = 11'(MAX_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } wrState_t;

    wrState_t    wrState;
    logic [9:0]  wrAddr;
    logic [10:0] wrRemain;
    logic [10:0] startCount;

    logic        hazard0, hazard1;
    logic        elig0, elig1;
    logic        gnt0, gnt1;
    logic        lastGnt1;
    logic [11:0] addrBHold;
    logic [RD_LAT-1:0] pipeV;
    logic [RD_LAT-1:0] pipeId;

    // ---------------- write path ----------------
    assign startCount = (ivWrCount > MAX_CNT) ? MAX_CNT : ivWrCount;

    // Ready drops on the abort cycle so the handshake never reports a word
    // that is not actually written.
    assign oWrReady   = (wrState == BURST) && !iWrAbort;
    assign oMemWE     = oWrReady && iWrValid;
    assign ovMemAddrA = wrAddr;
    assign ovMemDataA = oMemWE ? ivWrData : 32'd0;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wrState    <= IDLE;
            wrAddr     <= '0;
            wrRemain   <= '0;
            oWrDone    <= 1'b0;
            oWrAborted <= 1'b0;
        end else begin
            oWrDone    <= 1'b0;
            oWrAborted <= 1'b0;
            case (wrState)
                IDLE: begin
                    if (iWrStart) begin
                        wrAddr   <= ivWrBase;
                        wrRemain <= startCount;
                        if (startCount == 11'd0) begin
                            wrState <= DONE;
                            oWrDone <= 1'b1;
                        end else begin
                            wrState <= BURST;
                        end
                    end
                end
                BURST: begin
                    if (iWrAbort) begin
                        wrState    <= IDLE;
                        oWrAborted <= 1'b1;
                    end else if (iWrValid) begin
                        wrAddr   <= wrAddr + 10'd1;
                        wrRemain <= wrRemain - 11'd1;
                        if (wrRemain == 11'd1) begin
                            wrState <= DONE;
                            oWrDone <= 1'b1;
                        end
                    end
                end
                DONE:    wrState <= IDLE;
                default: wrState <= IDLE;
            endcase
        end
    end

    // ---------------- read arbiter ----------------
    // A read of the word being written this very cycle would return stale
    // data from the memory, so that requester sits out one cycle.
    assign hazard0 = oMemWE && (ivRdAddr0[11:2] == wrAddr);
    assign hazard1 = oMemWE && (ivRdAddr1[11:2] == wrAddr);

    // Reset gates the combinational grants so every output is quiet while
    // iRst_n is low, even with requests held high.
    assign elig0 = iRst_n && iRdReq0 && !hazard0;
    assign elig1 = iRst_n && iRdReq1 && !hazard1;

    assign gnt0 = elig0 && (!elig1 || lastGnt1);
    assign gnt1 = elig1 && (!elig0 || !lastGnt1);

    assign oRdGnt0    = gnt0;
    assign oRdGnt1    = gnt1;
    assign ovMemAddrB = gnt0 ? ivRdAddr0 : (gnt1 ? ivRdAddr1 : addrBHold);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            lastGnt1  <= 1'b1;
            addrBHold <= '0;
            pipeV     <= '0;
            pipeId    <= '0;
        end else begin
            if (gnt0 || gnt1) begin
                lastGnt1  <= gnt1;
                addrBHold <= ovMemAddrB;
            end
            // Tag pipeline tracks the memory's read latency: the tag entering
            // at the grant leaves exactly when its byte arrives.
            pipeV[0]  <= gnt0 || gnt1;
            pipeId[0] <= gnt1;
            for (int i = 1; i < RD_LAT; i++) begin
                pipeV[i]  <= pipeV[i-1];
                pipeId[i] <= pipeId[i-1];
            end
        end
    end

    assign oRdValid0 = pipeV[RD_LAT-1] && !pipeId[RD_LAT-1];
    assign oRdValid1 = pipeV[RD_LAT-1] &&  pipeId[RD_LAT-1];
    assign ovRdData  = iRst_n ? ivMemDataB : 8'd0;

    assign oBusy = (wrState != IDLE) || (|pipeV);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Drives directed scenarios and randomized traffic into mem_access_ctrl with
// a two-stage memory model, and compares every output each cycle against a
// cycle-level reference built from a shadow memory and a queue of pending
// read returns.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int RD_LAT = 2;

    logic        iClk = 1'b0;
    logic        iRst_n = 1'b0;
    logic        iWrStart = 1'b0;
    logic [9:0]  ivWrBase = '0;
    logic [10:0] ivWrCount = '0;
    logic        iWrValid = 1'b0;
    logic [31:0] ivWrData = '0;
    logic        oWrReady;
    logic        iWrAbort = 1'b0;
    logic        oWrDone, oWrAborted;
    logic        iRdReq0 = 1'b0, iRdReq1 = 1'b0;
    logic [11:0] ivRdAddr0 = '0, ivRdAddr1 = '0;
    logic        oRdGnt0, oRdGnt1, oRdValid0, oRdValid1;
    logic [7:0]  ovRdData;
    logic        oMemWE;
    logic [9:0]  ovMemAddrA;
    logic [31:0] ovMemDataA;
    logic [11:0] ovMemAddrB;
    logic [7:0]  ivMemDataB;
    logic        oBusy;

    always #5 iClk = ~iClk;

    mem_access_ctrl #(.RD_LAT(RD_LAT), .MAX_WORDS(1024)) dut (
        .iClk(iClk), .iRst_n(iRst_n),
        .iWrStart(iWrStart), .ivWrBase(ivWrBase), .ivWrCount(ivWrCount),
        .iWrValid(iWrValid), .ivWrData(ivWrData), .oWrReady(oWrReady),
        .iWrAbort(iWrAbort), .oWrDone(oWrDone), .oWrAborted(oWrAborted),
        .iRdReq0(iRdReq0), .iRdReq1(iRdReq1),
        .ivRdAddr0(ivRdAddr0), .ivRdAddr1(ivRdAddr1),
        .oRdGnt0(oRdGnt0), .oRdGnt1(oRdGnt1),
        .oRdValid0(oRdValid0), .oRdValid1(oRdValid1), .ovRdData(ovRdData),
        .oMemWE(oMemWE), .ovMemAddrA(ovMemAddrA), .ovMemDataA(ovMemDataA),
        .ovMemAddrB(ovMemAddrB), .ivMemDataB(ivMemDataB), .oBusy(oBusy)
    );

    // Memory: word write port, two-stage byte read (address reg, data reg).
    bit [31:0]   memArr [1024];
    logic [11:0] rdAddrStage;
    always @(posedge iClk) begin
        if (oMemWE) memArr[ovMemAddrA] <= ovMemDataA;
        rdAddrStage <= ovMemAddrB;
        ivMemDataB  <= 8'(memArr[rdAddrStage[11:2]] >> (8 * rdAddrStage[1:0]));
    end

    int vecCount = 0;
    int errCount = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {int due; int who; int data;} ret_t;
    ret_t      retQ[$];
    bit [31:0] shadow [1024];
    int        mPhase = 0;      // 0 idle, 1 burst, 2 done
    int        mNext = 0;
    int        mLeft = 0;
    bit        mAbortPulse = 0;
    int        mPrefer = 0;
    int        mLastB = 0;
    int        mCyc = 0;
    bit        mGot0 = 0, mGot1 = 0;

    task automatic modelStep();
        bit we, rdy, hz0, hz1, el0, el1, v0, v1, busy;
        int g, expB, vData, addr, cnt;
        if (!iRst_n) begin
            checkVal("rst_ready", 32'(oWrReady), 32'(0));
            checkVal("rst_we", 32'(oMemWE), 32'(0));
            checkVal("rst_done", 32'(oWrDone), 32'(0));
            checkVal("rst_aborted", 32'(oWrAborted), 32'(0));
            checkVal("rst_gnt", 32'({oRdGnt1, oRdGnt0}), 32'(0));
            checkVal("rst_valid", 32'({oRdValid1, oRdValid0}), 32'(0));
            checkVal("rst_addrA", 32'(ovMemAddrA), 32'(0));
            checkVal("rst_dataA", ovMemDataA, 32'(0));
            checkVal("rst_addrB", 32'(ovMemAddrB), 32'(0));
            checkVal("rst_rdData", 32'(ovRdData), 32'(0));
            checkVal("rst_busy", 32'(oBusy), 32'(0));
            mPhase = 0; mNext = 0; mLeft = 0; mAbortPulse = 0;
            mPrefer = 0; mLastB = 0; retQ.delete(); mGot0 = 0; mGot1 = 0;
            mCyc++;
            return;
        end
        rdy = (mPhase == 1) && !iWrAbort;
        we  = rdy && iWrValid;
        hz0 = iRdReq0 && we && (int'(ivRdAddr0[11:2]) == mNext);
        hz1 = iRdReq1 && we && (int'(ivRdAddr1[11:2]) == mNext);
        el0 = iRdReq0 && !hz0;
        el1 = iRdReq1 && !hz1;
        g = -1;
        if (el0 && el1) g = mPrefer;
        else if (el0)   g = 0;
        else if (el1)   g = 1;
        expB = (g == 0) ? int'(ivRdAddr0) : ((g == 1) ? int'(ivRdAddr1) : mLastB);
        v0 = 0; v1 = 0; vData = 0;
        if (retQ.size() > 0 && retQ[0].due == mCyc) begin
            v0 = (retQ[0].who == 0);
            v1 = (retQ[0].who == 1);
            vData = retQ[0].data;
        end
        busy = (mPhase != 0) || (retQ.size() > 0);

        checkVal("wr_ready", 32'(oWrReady), 32'(rdy));
        checkVal("mem_we", 32'(oMemWE), 32'(we));
        if (we) checkVal("mem_addrA", 32'(ovMemAddrA), 32'(mNext));
        checkVal("mem_dataA", ovMemDataA, we ? ivWrData : 32'(0));
        checkVal("wr_done", 32'(oWrDone), 32'(mPhase == 2));
        checkVal("wr_aborted", 32'(oWrAborted), 32'(mAbortPulse));
        checkVal("rd_gnt0", 32'(oRdGnt0), 32'(g == 0));
        checkVal("rd_gnt1", 32'(oRdGnt1), 32'(g == 1));
        checkVal("mem_addrB", 32'(ovMemAddrB), 32'(expB));
        checkVal("rd_valid0", 32'(oRdValid0), 32'(v0));
        checkVal("rd_valid1", 32'(oRdValid1), 32'(v1));
        if (v0 || v1) checkVal("rd_data", 32'(ovRdData), 32'(vData));
        checkVal("busy", 32'(oBusy), 32'(busy));

        if (v0 || v1) void'(retQ.pop_front());
        if (g >= 0) begin
            addr = (g == 0) ? int'(ivRdAddr0) : int'(ivRdAddr1);
            retQ.push_back('{mCyc + RD_LAT, g,
                             int'((shadow[addr / 4] >> (8 * (addr % 4))) & 32'hFF)});
            mPrefer = 1 - g;
            mLastB  = addr;
        end
        mGot0 = (g == 0);
        mGot1 = (g == 1);
        mAbortPulse = 0;
        case (mPhase)
            0: if (iWrStart) begin
                cnt = int'(ivWrCount);
                if (cnt > 1024) cnt = 1024;
                mNext  = int'(ivWrBase);
                mLeft  = cnt;
                mPhase = (cnt == 0) ? 2 : 1;
            end
            1: if (iWrAbort) begin
                mPhase = 0;
                mAbortPulse = 1;
            end else if (we) begin
                shadow[mNext] = ivWrData;
                mNext = (mNext + 1) % 1024;
                mLeft--;
                if (mLeft == 0) mPhase = 2;
            end
            default: mPhase = 0;
        endcase
        mCyc++;
    endtask

    always @(negedge iClk) modelStep();

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic idleInputs();
        iWrStart = 0; iWrValid = 0; iWrAbort = 0;
        iRdReq0 = 0; iRdReq1 = 0;
    endtask

    function automatic logic [11:0] pickAddr();
        if ($urandom_range(0, 2) == 0) return {10'(mNext), 2'($urandom)};
        return 12'($urandom);
    endfunction

    logic [9:0] b35Addr [4];
    int  nWr;
    bit  gotIt;

    initial begin
        b35Addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        tick(); tick(); tick();
        iRst_n = 1;

        // burst wrapping across the top of the word space
        tick();
        iWrStart = 1; ivWrBase = 10'h3FE; ivWrCount = 11'd4;
        tick();
        iWrStart = 0;
        for (int k = 0; k < 4; k++) begin
            iWrValid = 1; ivWrData = $urandom;
            @(negedge iClk);
            checkVal("b35_we", 32'(oMemWE), 32'(1));
            checkVal("b35_addr", 32'(ovMemAddrA), 32'(b35Addr[k]));
            tick();
        end
        iWrValid = 0;
        @(negedge iClk);
        checkVal("b35_done", 32'(oWrDone), 32'(1));
        tick();

        // both requesters held from reset release: 0,1,0,1...
        iRst_n = 0;
        tick(); tick();
        iRst_n = 1;
        iRdReq0 = 1; ivRdAddr0 = 12'h102;
        iRdReq1 = 1; ivRdAddr1 = 12'h207;
        for (int k = 0; k < 6; k++) begin
            @(negedge iClk);
            checkVal("b36_gnt0", 32'(oRdGnt0), 32'(k % 2 == 0));
            checkVal("b36_gnt1", 32'(oRdGnt1), 32'(k % 2 == 1));
            tick();
        end
        idleInputs();
        tick(); tick(); tick();

        // read of the word being written is deferred by one cycle
        iWrStart = 1; ivWrBase = 10'h010; ivWrCount = 11'd1;
        tick();
        iWrStart = 0; iWrValid = 1; ivWrData = 32'hAABBCCDD;
        iRdReq0 = 1; ivRdAddr0 = 12'h041;
        @(negedge iClk);
        checkVal("b37_we", 32'(oMemWE), 32'(1));
        checkVal("b37_deferred", 32'(oRdGnt0), 32'(0));
        tick();
        iWrValid = 0;
        @(negedge iClk);
        checkVal("b37_gnt", 32'(oRdGnt0), 32'(1));
        tick();
        iRdReq0 = 0;
        tick();
        @(negedge iClk);
        checkVal("b37_valid", 32'(oRdValid0), 32'(1));
        checkVal("b37_byte", 32'(ovRdData), 32'(8'hCC));
        tick();

        // zero-length burst
        iWrStart = 1; ivWrBase = 10'($urandom); ivWrCount = 11'd0;
        tick();
        iWrStart = 0;
        @(negedge iClk);
        checkVal("b38_zero_done", 32'(oWrDone), 32'(1));
        checkVal("b38_zero_we", 32'(oMemWE), 32'(0));
        tick();

        // oversized burst clamps to 1024 words
        iWrStart = 1; ivWrBase = 10'($urandom); ivWrCount = 11'd2000; iWrValid = 1;
        tick();
        iWrStart = 0;
        nWr = 0; gotIt = 0;
        for (int c = 0; c < 1200 && !gotIt; c++) begin
            ivWrData = $urandom;
            @(negedge iClk);
            if (oMemWE) nWr++;
            if (oWrDone) gotIt = 1;
            tick();
        end
        checkVal("b38_clamp_writes", 32'(nWr), 32'(1024));
        checkVal("b38_clamp_done", 32'(gotIt), 32'(1));
        iWrValid = 0;
        tick();

        // abort after two words, restart the following cycle
        iWrStart = 1; ivWrBase = 10'h155; ivWrCount = 11'd8; iWrValid = 1;
        tick();
        iWrStart = 0;
        nWr = 0;
        for (int k = 0; k < 2; k++) begin
            ivWrData = $urandom;
            @(negedge iClk);
            if (oMemWE) nWr++;
            tick();
        end
        iWrAbort = 1;
        @(negedge iClk);
        checkVal("b39_abort_nowe", 32'(oMemWE), 32'(0));
        tick();
        iWrAbort = 0; iWrStart = 1; ivWrBase = 10'h020; ivWrCount = 11'd1;
        @(negedge iClk);
        checkVal("b39_aborted", 32'(oWrAborted), 32'(1));
        checkVal("b39_writes", 32'(nWr), 32'(2));
        tick();
        iWrStart = 0; iWrValid = 0;
        @(negedge iClk);
        checkVal("b39_restart", 32'(oWrReady), 32'(1));
        tick();
        iWrValid = 1;
        tick();
        iWrValid = 0;
        tick();

        // reset right after a grant kills the in-flight read
        iRdReq0 = 1; ivRdAddr0 = 12'($urandom);
        gotIt = 0;
        for (int c = 0; c < 10 && !gotIt; c++) begin
            @(negedge iClk);
            if (oRdGnt0) gotIt = 1;
            else tick();
        end
        checkVal("b40_grant", 32'(gotIt), 32'(1));
        tick();
        iRst_n = 0;
        #1;
        checkVal("b40_rst_valid", 32'({oRdValid1, oRdValid0}), 32'(0));
        checkVal("b40_rst_gnt", 32'({oRdGnt1, oRdGnt0}), 32'(0));
        checkVal("b40_rst_busy", 32'(oBusy), 32'(0));
        checkVal("b40_rst_addrB", 32'(ovMemAddrB), 32'(0));
        tick(); tick();
        iRst_n = 1; iRdReq0 = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge iClk);
            checkVal("b40_no_valid", 32'(oRdValid0), 32'(0));
            tick();
        end

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            iWrStart = ($urandom_range(0, 9) == 0);
            ivWrBase = 10'($urandom);
            case ($urandom_range(0, 63))
                0:       ivWrCount = 11'($urandom_range(1025, 2047));
                1, 2, 3: ivWrCount = 11'd0;
                4, 5, 6: ivWrCount = 11'($urandom_range(1, 3));
                default: ivWrCount = 11'($urandom_range(1, 24));
            endcase
            iWrValid = ($urandom_range(0, 3) != 0);
            ivWrData = $urandom;
            iWrAbort = ($urandom_range(0, 49) == 0);
            if (!iRdReq0 || mGot0) begin
                iRdReq0 = 1'($urandom_range(0, 1));
                ivRdAddr0 = pickAddr();
            end
            if (!iRdReq1 || mGot1) begin
                iRdReq1 = 1'($urandom_range(0, 1));
                ivRdAddr1 = pickAddr();
            end
            if ($urandom_range(0, 599) == 0) begin
                iRst_n = 0;
                tick();
                iRst_n = 1;
            end else begin
                tick();
            end
        end

        idleInputs();
        tick(); tick(); tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
